// File: rtl/rf_set_pkg.sv
// Shared constants and types for the rf_set register file.
// Provides the default word/address widths, the derived register count,
// and the address/data typedefs used by the register file and its bench.
package rf_set_pkg;

    localparam int RF_DATA_W   = 4;
    localparam int RF_ADDR_W   = 2;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : rf_set_pkg

// File: rtl/rf_read_port.sv
// Purpose : one combinational read port of the rf_set register file.
// Ports   : regs_i (all stored words), raddr_i -> rdata_o; rst_i/we_i/waddr_i/wdata_i
//           feed the optional write-first bypass (macro RFSET_BYPASS_EN).
// Latency : zero; rdata_o follows raddr_i and the stored words combinationally.
module rf_read_port
    import rf_set_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]               raddr_i,
    input  logic                            rst_i,
    input  logic                            we_i,
    input  logic [ADDR_W-1:0]               waddr_i,
    input  logic [DATA_W-1:0]               wdata_i,
    output logic [DATA_W-1:0]               rdata_o
);

`ifdef RFSET_BYPASS_EN
    // Write-first: a read that hits the address being written this cycle
    // sees the incoming data immediately. Reset wins so the bypass cannot
    // leak write data while the array is being cleared.
    always_comb begin
        rdata_o = regs_i[raddr_i];
        if (rst_i) begin
            rdata_o = '0;
        end else if (we_i && (raddr_i == waddr_i)) begin
            rdata_o = wdata_i;
        end
    end
`else
    // Stored contents only; reset already holds the array at zero, so the
    // write-port and reset inputs have no effect in this build.
    assign rdata_o = regs_i[raddr_i];

    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{rst_i, we_i, waddr_i, wdata_i};
`endif

endmodule : rf_read_port

// File: rtl/rf_set.sv
// Purpose : NUM_REGS x DATA_W register file, one synchronous write port, two async read ports.
// Ports   : clk/reset (async, active-high); RE/WR/WRD write port; RA->A and RB->B read ports.
// Options : define RFSET_BYPASS_EN for write-first bypass on reads (default: no bypass).
module rf_set
    import rf_set_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic              RE,
    input  logic [ADDR_W-1:0] WR,
    input  logic [DATA_W-1:0] WRD,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

    // Write decode: only the addressed word takes new data, the rest hold.
    always_comb begin
        regs_d = regs_q;
        if (RE) begin
            regs_d[WR] = WRD;
        end
    end

    // Reset clears the whole array without a clock and overrides any write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_a (
        .regs_i  (regs_q),
        .raddr_i (RA),
        .rst_i   (reset),
        .we_i    (RE),
        .waddr_i (WR),
        .wdata_i (WRD),
        .rdata_o (A)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_b (
        .regs_i  (regs_q),
        .raddr_i (RB),
        .rst_i   (reset),
        .we_i    (RE),
        .waddr_i (WR),
        .wdata_i (WRD),
        .rdata_o (B)
    );

endmodule : rf_set

// File: tb/tb_rf_set.sv
// Directed, table-driven bench for rf_set (works with or without RFSET_BYPASS_EN).
module tb_rf_set;
    import rf_set_pkg::*;

    logic     clk;
    logic     reset;
    rf_addr_t RA, RB, WR;
    logic     RE;
    rf_data_t WRD;
    rf_data_t A, B;

    int n_cmp;
    int n_bad;

    rf_set dut (
        .clk   (clk),
        .reset (reset),
        .RA    (RA),
        .RB    (RB),
        .RE    (RE),
        .WR    (WR),
        .WRD   (WRD),
        .A     (A),
        .B     (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string    name;
        logic     re;
        rf_addr_t wr;
        rf_data_t wrd;
        rf_addr_t ra;
        rf_addr_t rb;
        logic     do_clk;
        rf_data_t exp_a;
        rf_data_t exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input rf_data_t act, input rf_data_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input rf_addr_t wr, input rf_data_t wrd,
                         input rf_addr_t ra, input rf_addr_t rb);
        RE = re; WR = wr; WRD = wrd; RA = ra; RB = rb;
    endtask

    task automatic add(input string name, input logic re, input rf_addr_t wr, input rf_data_t wrd,
                       input rf_addr_t ra, input rf_addr_t rb, input logic do_clk,
                       input rf_data_t ea, input rf_data_t eb);
        vec_t v;
        v.name = name; v.re = re; v.wr = wr; v.wrd = wrd; v.ra = ra; v.rb = rb;
        v.do_clk = do_clk; v.exp_a = ea; v.exp_b = eb;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(1'b0, 2'd0, 4'd0, 2'd0, 2'd0);

        // Write/readback, each with RA=RB=WR, checked just after the edge.
        add("wr_r0", 1'b1, 2'd0, 4'b1101, 2'd0, 2'd0, 1'b1, 4'b1101, 4'b1101);
        add("wr_r1", 1'b1, 2'd1, 4'b0011, 2'd1, 2'd1, 1'b1, 4'b0011, 4'b0011);
        add("wr_r2", 1'b1, 2'd2, 4'b1010, 2'd2, 2'd2, 1'b1, 4'b1010, 4'b1010);
        add("wr_r3", 1'b1, 2'd3, 4'b0111, 2'd3, 2'd3, 1'b1, 4'b0111, 4'b0111);
        // Sweep of all read addresses on both ports.
        add("sweep0", 1'b0, 2'd0, 4'b0000, 2'd0, 2'd1, 1'b0, 4'b1101, 4'b0011);
        add("sweep1", 1'b0, 2'd0, 4'b0000, 2'd1, 2'd2, 1'b0, 4'b0011, 4'b1010);
        add("sweep2", 1'b0, 2'd0, 4'b0000, 2'd2, 2'd3, 1'b0, 4'b1010, 4'b0111);
        add("sweep3", 1'b0, 2'd0, 4'b0000, 2'd3, 2'd0, 1'b0, 4'b0111, 4'b1101);
        // Write disabled: WR/WRD must be ignored across two edges.
        add("wdis_e1", 1'b0, 2'd0, 4'b1111, 2'd0, 2'd0, 1'b1, 4'b1101, 4'b1101);
        add("wdis_e2", 1'b0, 2'd0, 4'b1111, 2'd0, 2'd0, 1'b1, 4'b1101, 4'b1101);
        // Dual-port independence, swapped without a clock edge.
        add("dual_ab", 1'b0, 2'd0, 4'b0000, 2'd1, 2'd2, 1'b0, 4'b0011, 4'b1010);
        add("dual_ba", 1'b0, 2'd0, 4'b0000, 2'd2, 2'd1, 1'b0, 4'b1010, 4'b0011);

        // Reset state.
        #2;
        chk("rst_init_a", A, 4'b0000);
        chk("rst_init_b", B, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].re, vecs[i].wr, vecs[i].wrd, vecs[i].ra, vecs[i].rb);
            if (vecs[i].do_clk) @(posedge clk);
            #1;
            chk({vecs[i].name, "_a"}, A, vecs[i].exp_a);
            chk({vecs[i].name, "_b"}, B, vecs[i].exp_b);
        end

        // Write isolation: writing R2 leaves the others alone.
        @(negedge clk);
        drive(1'b1, 2'd2, 4'b0000, 2'd0, 2'd1);
        @(posedge clk); #1;
        RE = 1'b0;
        #1;
        chk("iso_r0", A, 4'b1101);
        chk("iso_r1", B, 4'b0011);
        RA = 2'd3; RB = 2'd2;
        #1;
        chk("iso_r3", A, 4'b0111);
        chk("iso_r2", B, 4'b0000);

        // Same-cycle write and read of R3.
        @(negedge clk);
        drive(1'b1, 2'd3, 4'b0001, 2'd3, 2'd0);
        #1;
`ifdef RFSET_BYPASS_EN
        chk("same_pre_a", A, 4'b0001);
`else
        chk("same_pre_a", A, 4'b0111);
`endif
        chk("same_pre_b", B, 4'b1101);
        @(posedge clk); #1;
        chk("same_post_a", A, 4'b0001);
        RE = 1'b0;
        #1;
        chk("same_stored_a", A, 4'b0001);

        // Refill R2 so every register is nonzero, then reset mid-cycle with a
        // write pending to R1.
        @(negedge clk);
        drive(1'b1, 2'd2, 4'b1010, 2'd2, 2'd2);
        @(posedge clk); #1;
        chk("refill_r2", A, 4'b1010);
        @(negedge clk);
        drive(1'b1, 2'd1, 4'b1111, 2'd1, 2'd1);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            RA = rf_addr_t'(i);
            RB = rf_addr_t'(3 - i);
            #1;
            chk($sformatf("rst_mid_a%0d", i), A, 4'b0000);
            chk($sformatf("rst_mid_b%0d", i), B, 4'b0000);
        end
        // An edge while reset is held must not write.
        RA = 2'd1; RB = 2'd1;
        @(posedge clk); #1;
        chk("rst_edge_a", A, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        RE = 1'b0;
        #1;
        chk("rst_lost_r1", A, 4'b0000);
        RA = 2'd0; RB = 2'd3;
        #1;
        chk("rst_clr_r0", A, 4'b0000);
        chk("rst_clr_r3", B, 4'b0000);

        // First edge after reset release performs the write.
        @(negedge clk);
        drive(1'b1, 2'd1, 4'b0110, 2'd1, 2'd0);
        @(posedge clk); #1;
        RE = 1'b0;
        #1;
        chk("post_rst_wr_a", A, 4'b0110);
        chk("post_rst_wr_b", B, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rf_set
